// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS-style core front end.
//   fetch_state_t : fetch-stage sequencer states
//   RESET_VECTOR  : default PC after reset
//   OP_*          : primary opcode field values (instr[31:26]) used by the decoder
//   INSTR_W       : instruction word width
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// ---------------------------------------------------------------------------
// fetch_pc_next
// Combinational next-PC calculation for the fetch stage.
//   pc_i       in  32  address of the held instruction
//   target_i   in  26  instr[25:0], jump target word index
//   jal_i      in  1   held instruction is a jal
//   next_pc_o  out 32  address of the following fetch
//   link_pc_o  out 32  pc + 4 (return address for jal)
// ---------------------------------------------------------------------------
module fetch_pc_next (
    input  logic [31:0] pc_i,
    input  logic [25:0] target_i,
    input  logic        jal_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] link_pc_o
);

    // Plain 32-bit add: 0xFFFF_FFFC + 4 wraps to 0 by design.
    assign link_pc_o = pc_i + 32'd4;

    // Jump target keeps the 256 MB region of the delay-slot address (pc+4),
    // not of pc itself; the two differ only at a region boundary.
    assign next_pc_o = jal_i ? {link_pc_o[31:28], target_i, 2'b00} : link_pc_o;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Single-issue instruction fetch stage. Owns the PC, fetches one word at a
// time over a req/ack port, holds it for the decoder until the core retires it,
// and redirects on the decoder's jal flag.
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and address (address = pc)
//   imem_ack/rdata    memory response, sampled only while requesting
//   stall             core not ready to retire the held instruction
//   jal               decoder flag for the held instruction
//   instr/instr_valid held instruction and its live flag
//   opcode/func       instr[31:26] / instr[5:0] to the decoder
//   pc/link_pc        address of held instruction and pc + 4
// ---------------------------------------------------------------------------
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              jal,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [31:0]         next_pc;
    logic [31:0]         link_pc_w;

    fetch_pc_next u_pc_next (
        .pc_i      (pc_q),
        .target_i  (instr_q[25:0]),
        .jal_i     (jal),
        .next_pc_o (next_pc),
        .link_pc_o (link_pc_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            // Idle cycle after reset release before the first request.
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            // jal is only consulted here, when the instruction retires.
            HOLD: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs decode straight from the state register so an asynchronous
    // reset drops imem_req without waiting for a clock edge.
    always_comb begin
        imem_req    = (state_q == REQ);
        instr_valid = (state_q == HOLD);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign link_pc   = link_pc_w;
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];
    assign func      = instr_q[5:0];

endmodule
